avalon_multi_timer: RTL
=======================

// Module: avalon_multi_timer
// PURPOSE
//  Parametrised Avalon-MM interval timer: NUM_CH independent down-counters, one shared slave port.
//  Per channel: prescaler, one-shot/continuous mode, snapshot, sticky timeout, maskable IRQ.
//  Successor to the single-channel 16-bit-bus system timer; sits on the Nios II data master
//  as the system tick plus general-purpose timers.
// PARAMETERS
//  NUM_CH       2            number of channels, 1..8
//  CNT_W        32           counter/period width, 8..32
//  PRESC_W      8            prescaler divisor width, 0..16 (0 = no prescaler, tick every clk)
//  PERIOD_RST   32'h0001869F reset value of PERIOD and counter, truncated to CNT_W
// PORTS
//  clk        in   1                        system clock
//  reset      in   1                        async, active-high reset
//  address    in   $clog2(NUM_CH)+2         word address = {channel, reg[1:0]}
//  chipselect in   1                        slave select
//  write_n    in   1                        active-low write strobe
//  read_n     in   1                        active-low read strobe (readdata updates regardless)
//  writedata  in   32                       write data
//  readdata   out  32                       registered read data, 1-cycle latency
//  irq        out  1                        OR of irq_ch
//  irq_ch     out  NUM_CH                   per-channel interrupt = TO & ITO
// BEHAVIOUR
//  Reset, async: counter=PERIOD=PERIOD_RST, CTRL=0, TO=0, RUN=0, SNAP=0, prescale cnt=0,
//   readdata=0, irq=irq_ch=0.
//  Register map, per channel, reg index:
//   0 STATUS  R: [0]TO [1]RUN, others 0. Any write clears TO.
//   1 CTRL    RW: [0]ITO [1]CONT [8+:PRESC_W]DIV. Side-effect bits, not stored, read 0:
//             [2]START [3]STOP.
//   2 PERIOD  RW: [CNT_W-1:0]. Write also forces counter=new value, RUN=0,
//             and prescale cnt=0 on the next clk.
//   3 SNAP    write (any data) latches live counter; read returns the latched value.
//  Unused bits read 0. Accesses to channel index >= NUM_CH: reads return 0, writes are ignored.
//  Write access: chipselect & ~write_n, single cycle, no wait states.
//  Read access: readdata <= mux(address) every clk, so data is valid the cycle after address.
//  Tick: with RUN=1, prescale cnt counts 0..DIV, and tick=1 when cnt==DIV (DIV=0 => every clk).
//   With RUN=0, cnt is held at 0.
//  Counter on tick: if counter==0, reload PERIOD and raise event; else decrement by 1.
//   Interval = (PERIOD+1)*(DIV+1) clks.
//  Event: TO<=1. If CONT=0, RUN<=0 in the same cycle (counter already reloaded).
//   If CONT=1, RUN stays 1.
//  START: RUN<=1 and prescale cnt<=0. Counter keeps its current value and does not reload.
//   START while running restarts only the prescaler.
//  STOP: RUN<=0. Counter and prescale cnt hold.
//  START and STOP in the same write: START wins.
//  Event and STATUS write in the same cycle: event wins, TO stays 1 (no lost timeout).
//  PERIOD write while running: counter loads, RUN=0, and no event fires that cycle.
//  PERIOD=0 with CONT=1: event on every tick.
//  SNAP write in the same cycle as a decrement: captures the pre-decrement value.
//  irq_ch and irq are combinational from registered TO/ITO (no extra latency).
//   Clearing ITO drops irq_ch the next cycle while TO stays set.
//  Reset asserted mid-count: all state returns to reset values immediately;
//   the counter restarts only on a new START.
// TESTING
//  T1 NUM_CH=2, DIV=0, ch0 PERIOD=4, CONT=0, ITO=1, START -> TO/irq rise exactly 5 clk after
//     START takes effect; RUN=0 after; counter=4.
//  T2 ch1 PERIOD=9, DIV=3, CONT=1 -> events every 40 clk, five in a row; ch0 untouched (TO=0).
//  T3 STATUS write in the same clk as an event -> TO stays 1; a STATUS write 1 clk later
//     -> TO=0, irq=0.
//  T4 running with counter=0x1234, SNAP write, then read reg3 -> 0x1234 exactly
//     1 clk after the read address.
//  T5 CTRL write with START|STOP -> RUN=1; then PERIOD write while running -> RUN=0,
//     counter=new PERIOD, no TO.
//  T6 assert reset mid-count (counter=3) -> readdata=0, irq=0, counter=PERIOD_RST,
//     RUN=0 in the same cycle.

Source files
------------

// File: rtl/avalon_multi_timer.sv
// Avalon-MM multi-channel interval timer: NUM_CH down-counters with prescaler,
// one-shot/continuous mode, snapshot, sticky timeout and maskable interrupt.
module avalon_multi_timer #(
    parameter int          NUM_CH     = 2,
    parameter int          CNT_W      = 32,
    parameter int          PRESC_W    = 8,
    parameter logic [31:0] PERIOD_RST = 32'h0001869F
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NUM_CH)+1:0] address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic                      read_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic                      irq,
    output logic [NUM_CH-1:0]         irq_ch
);

    localparam int AW = $clog2(NUM_CH) + 2;
    localparam int PW = (PRESC_W > 0) ? PRESC_W : 1;
    localparam logic [CNT_W-1:0] CNT_RST = PERIOD_RST[CNT_W-1:0];

    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] period_q [NUM_CH];
    logic [CNT_W-1:0] snap_q   [NUM_CH];
    logic [PW-1:0]    div_q    [NUM_CH];
    logic [PW-1:0]    pcnt_q   [NUM_CH];
    logic [NUM_CH-1:0] ito_q, cont_q, to_q, run_q;

    logic [NUM_CH-1:0] sel, tick, evt;
    logic [NUM_CH-1:0] wr_sts, wr_ctrl, wr_per, wr_snap;
    logic [AW-1:0]     ch_idx;
    logic [1:0]        reg_idx;
    logic              wr_en;
    logic [31:0]       rd_mux;
    logic              unused_rd;

    // read strobe has no side effects; readdata follows the address every clock
    assign unused_rd = read_n;

    assign wr_en   = chipselect & ~write_n;
    assign ch_idx  = address >> 2;
    assign reg_idx = address[1:0];

    always_comb begin
        sel     = '0;
        tick    = '0;
        evt     = '0;
        wr_sts  = '0;
        wr_ctrl = '0;
        wr_per  = '0;
        wr_snap = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel[i]     = (ch_idx == AW'(i));
            tick[i]    = run_q[i] & (pcnt_q[i] == div_q[i]);
            // a PERIOD write reloads the counter and suppresses any event that cycle
            wr_per[i]  = wr_en & sel[i] & (reg_idx == 2'd2);
            evt[i]     = tick[i] & (cnt_q[i] == '0) & ~wr_per[i];
            wr_sts[i]  = wr_en & sel[i] & (reg_idx == 2'd0);
            wr_ctrl[i] = wr_en & sel[i] & (reg_idx == 2'd1);
            wr_snap[i] = wr_en & sel[i] & (reg_idx == 2'd3);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= CNT_RST;
                period_q[i] <= CNT_RST;
                snap_q[i]   <= '0;
                div_q[i]    <= '0;
                pcnt_q[i]   <= '0;
            end
            ito_q  <= '0;
            cont_q <= '0;
            to_q   <= '0;
            run_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_per[i]) begin
                    period_q[i] <= writedata[CNT_W-1:0];
                    cnt_q[i]    <= writedata[CNT_W-1:0];
                    run_q[i]    <= 1'b0;
                    pcnt_q[i]   <= '0;
                end else begin
                    if (tick[i])
                        cnt_q[i] <= (cnt_q[i] == '0) ? period_q[i] : cnt_q[i] - 1'b1;
                    if (run_q[i])
                        pcnt_q[i] <= tick[i] ? '0 : pcnt_q[i] + 1'b1;
                    if (evt[i] & ~cont_q[i])
                        run_q[i] <= 1'b0;
                    // START overrides both the one-shot stop and a simultaneous STOP
                    if (wr_ctrl[i]) begin
                        if (writedata[2]) begin
                            run_q[i]  <= 1'b1;
                            pcnt_q[i] <= '0;
                        end else if (writedata[3]) begin
                            run_q[i] <= 1'b0;
                        end
                    end
                end

                if (wr_ctrl[i]) begin
                    ito_q[i]  <= writedata[0];
                    cont_q[i] <= writedata[1];
                    div_q[i]  <= (PRESC_W > 0) ? writedata[8 +: PW] : '0;
                end

                if (evt[i])
                    to_q[i] <= 1'b1;
                else if (wr_sts[i])
                    to_q[i] <= 1'b0;

                if (wr_snap[i])
                    snap_q[i] <= cnt_q[i];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel[i]) begin
                case (reg_idx)
                    2'd0: rd_mux[1:0] = {run_q[i], to_q[i]};
                    2'd1: begin
                        rd_mux[0] = ito_q[i];
                        rd_mux[1] = cont_q[i];
                        if (PRESC_W > 0)
                            rd_mux[8 +: PW] = div_q[i];
                    end
                    2'd2:    rd_mux[CNT_W-1:0] = period_q[i];
                    default: rd_mux[CNT_W-1:0] = snap_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

    assign irq_ch = to_q & ito_q;
    assign irq    = |irq_ch;

endmodule
